// File: rtl/gpreg_sb.sv
// Parametrised register file (reg 0 hardwired to zero) with a per-register busy scoreboard.
// Optional write-to-read forwarding is enabled by defining GPREG_SB_BYPASS_EN.

module gpreg_sb_cell #(
   parameter int XLEN = 32,
   parameter int AW   = 5,
   parameter int IDX  = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rd_w,
   input  logic [AW-1:0]   rd_addr,
   input  logic [XLEN-1:0] rd,
   input  logic            iss_v,
   input  logic [AW-1:0]   iss_addr,
   input  logic            flush,
   output logic [XLEN-1:0] q,
   output logic            busy_q,
   output logic            busy_d
);
   localparam logic [AW-1:0] MY_ADDR = AW'(IDX);

   logic wr_hit, iss_hit;
   assign wr_hit  = rd_w  && (rd_addr  == MY_ADDR);
   assign iss_hit = iss_v && (iss_addr == MY_ADDR);

   // New producer supersedes a completing one; flush beats both.
   always_comb begin
      busy_d = busy_q;
      if (flush)        busy_d = 1'b0;
      else if (iss_hit) busy_d = 1'b1;
      else if (wr_hit)  busy_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q      <= '0;
         busy_q <= 1'b0;
      end else begin
         if (wr_hit) q <= rd;
         busy_q <= busy_d;
      end
   end
endmodule

module gpreg_sb #(
   parameter int XLEN = 32,
   parameter int AW   = 5,
   parameter int CW   = AW + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rd_w,
   input  logic [AW-1:0]   rd_addr,
   input  logic [XLEN-1:0] rd,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   output logic [XLEN-1:0] rs1,
   output logic [XLEN-1:0] rs2,
   input  logic            iss_v,
   input  logic [AW-1:0]   iss_addr,
   input  logic            flush,
   output logic            rs1_busy,
   output logic            rs2_busy,
   output logic [CW-1:0]   busy_cnt
);
   localparam int NREG = 2 ** AW;

   logic [NREG-1:0][XLEN-1:0] regs;
   logic [NREG-1:0]           busy_q;
   logic [NREG-1:0]           busy_d;
   logic [CW-1:0]             cnt_d;

   assign regs[0]   = '0;
   assign busy_q[0] = 1'b0;
   assign busy_d[0] = 1'b0;

   for (genvar i = 1; i < NREG; i++) begin : g_reg
      gpreg_sb_cell #(.XLEN(XLEN), .AW(AW), .IDX(i)) u_cell (
         .clk      (clk),
         .rst      (rst),
         .rd_w     (rd_w),
         .rd_addr  (rd_addr),
         .rd       (rd),
         .iss_v    (iss_v),
         .iss_addr (iss_addr),
         .flush    (flush),
         .q        (regs[i]),
         .busy_q   (busy_q[i]),
         .busy_d   (busy_d[i])
      );
   end

   // Count tracks the next-state vector so it lines up with the busy bits.
   always_comb begin
      cnt_d = '0;
      for (int i = 1; i < NREG; i++) cnt_d = cnt_d + CW'(busy_d[i]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy_cnt <= '0;
      else     busy_cnt <= cnt_d;
   end

   always_comb begin
      rs1      = regs[rs1_addr];
      rs2      = regs[rs2_addr];
      rs1_busy = busy_q[rs1_addr];
      rs2_busy = busy_q[rs2_addr];
`ifdef GPREG_SB_BYPASS_EN
      // Forwarding is suppressed under reset so outputs read zero immediately.
      if (!rst && rd_w && (rd_addr != '0) && (rd_addr == rs1_addr)) begin
         rs1      = rd;
         rs1_busy = iss_v && (iss_addr == rs1_addr);
      end
      if (!rst && rd_w && (rd_addr != '0) && (rd_addr == rs2_addr)) begin
         rs2      = rd;
         rs2_busy = iss_v && (iss_addr == rs2_addr);
      end
`endif
   end
endmodule

// File: tb/tb_gpreg_sb.sv
// Directed bench for gpreg_sb: table-driven scoreboard vectors plus hand sequences for sweeps, bypass and async reset.

module tb_gpreg_sb;
   logic        clk = 1'b0;
   logic        rst;
   logic        rd_w;
   logic [4:0]  rd_addr;
   logic [31:0] rd;
   logic [4:0]  rs1_addr, rs2_addr;
   logic [31:0] rs1, rs2;
   logic        iss_v;
   logic [4:0]  iss_addr;
   logic        flush;
   logic        rs1_busy, rs2_busy;
   logic [5:0]  busy_cnt;

   int errors = 0;
   int checks = 0;

   gpreg_sb dut (
      .clk(clk), .rst(rst), .rd_w(rd_w), .rd_addr(rd_addr), .rd(rd),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1(rs1), .rs2(rs2),
      .iss_v(iss_v), .iss_addr(iss_addr), .flush(flush),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .busy_cnt(busy_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rd_w;
      logic [4:0]  rd_addr;
      logic [31:0] rd;
      logic [4:0]  rs1_addr;
      logic [4:0]  rs2_addr;
      logic        iss_v;
      logic [4:0]  iss_addr;
      logic        flush;
      logic [31:0] e_rs1;
      logic [31:0] e_rs2;
      logic        e_b1;
      logic        e_b2;
      logic [5:0]  e_cnt;
   } vec_t;

   vec_t tbl [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_reg(input int a);
      return (a == 0) ? 32'd0 : 32'(32 - a);
   endfunction

   task automatic idle();
      rd_w = 0; rd_addr = 0; rd = 0; iss_v = 0; iss_addr = 0; flush = 0;
   endtask

   task automatic sweep(input string tag);
      for (int i = 0; i < 32; i++) begin
         rs1_addr = 5'(i);
         rs2_addr = 5'((32 - i) % 32);
         #1;
         check({tag, "_rs1"}, rs1, exp_reg(i));
         check({tag, "_rs2"}, rs2, exp_reg((32 - i) % 32));
      end
   endtask

   initial begin
      // scoreboard vectors: outputs observed after driving, before the edge
      //         rd_w addr rd        rs1 rs2 iss ia fl  e_rs1     e_rs2     b1 b2 cnt
      tbl[0]  = '{0, 0,  32'h0,    3,  5,  1, 3, 0, 32'd29,   32'd27,   0, 0, 0};
      tbl[1]  = '{0, 0,  32'h0,    3,  5,  1, 5, 0, 32'd29,   32'd27,   1, 0, 1};
      tbl[2]  = '{0, 0,  32'h0,    3,  5,  1, 0, 0, 32'd29,   32'd27,   1, 1, 2};
      tbl[3]  = '{1, 3,  32'h33,   0,  5,  0, 0, 0, 32'd0,    32'd27,   0, 1, 2};
      tbl[4]  = '{1, 5,  32'h55,   3,  1,  1, 5, 0, 32'h33,   32'd31,   0, 0, 1};
      tbl[5]  = '{0, 0,  32'h0,    5,  3,  0, 0, 0, 32'h55,   32'h33,   1, 0, 1};
      tbl[6]  = '{0, 0,  32'h0,    7,  9,  1, 7, 0, 32'd25,   32'd23,   0, 0, 1};
      tbl[7]  = '{0, 0,  32'h0,    7,  9,  1, 9, 0, 32'd25,   32'd23,   1, 0, 2};
      tbl[8]  = '{1, 10, 32'hA0,   7,  9,  1, 4, 1, 32'd25,   32'd23,   1, 1, 3};
      tbl[9]  = '{0, 0,  32'h0,    4,  10, 0, 0, 0, 32'd28,   32'hA0,   0, 0, 0};
      tbl[10] = '{0, 0,  32'h0,    5,  7,  0, 0, 0, 32'h55,   32'd25,   0, 0, 0};

      rst = 1; idle(); rs1_addr = 0; rs2_addr = 0;
      #2;
      check("reset_cnt", 32'(busy_cnt), 32'd0);
      @(negedge clk); rst = 0;

      // reset state reads
      rs1_addr = 1; rs2_addr = 18; #1;
      check("rst_rs1", rs1, 32'd0);
      check("rst_rs2", rs2, 32'd0);
      check("rst_cnt", 32'(busy_cnt), 32'd0);
      check("rst_busy", 32'(rs1_busy), 32'd0);

      // write 32-i everywhere, address 0 discarded
      for (int i = 0; i < 32; i++) begin
         @(negedge clk); rd_w = 1; rd_addr = 5'(i); rd = 32'(32 - i);
      end
      @(negedge clk); idle();
      sweep("wr");

      // rd_w low must not change anything
      for (int i = 0; i < 32; i++) begin
         @(negedge clk); rd_w = 0; rd_addr = 5'(i); rd = 32'(i);
      end
      @(negedge clk); idle();
      sweep("nowr");

      // scoreboard table
      for (int k = 0; k < 11; k++) begin
         @(negedge clk);
         rd_w = tbl[k].rd_w; rd_addr = tbl[k].rd_addr; rd = tbl[k].rd;
         rs1_addr = tbl[k].rs1_addr; rs2_addr = tbl[k].rs2_addr;
         iss_v = tbl[k].iss_v; iss_addr = tbl[k].iss_addr; flush = tbl[k].flush;
         #1;
         check($sformatf("v%0d_rs1", k), rs1, tbl[k].e_rs1);
         check($sformatf("v%0d_rs2", k), rs2, tbl[k].e_rs2);
         check($sformatf("v%0d_b1", k), 32'(rs1_busy), 32'(tbl[k].e_b1));
         check($sformatf("v%0d_b2", k), 32'(rs2_busy), 32'(tbl[k].e_b2));
         check($sformatf("v%0d_cnt", k), 32'(busy_cnt), 32'(tbl[k].e_cnt));
      end

      // same-cycle write and read of a busy register
      @(negedge clk); idle(); iss_v = 1; iss_addr = 6;
      @(negedge clk); idle();
      rs1_addr = 6; rd_w = 1; rd_addr = 6; rd = 32'hDEAD_BEEF; #1;
`ifdef GPREG_SB_BYPASS_EN
      check("byp_rs1", rs1, 32'hDEAD_BEEF);
      check("byp_busy", 32'(rs1_busy), 32'd0);
`else
      check("byp_rs1", rs1, 32'd26);
      check("byp_busy", 32'(rs1_busy), 32'd1);
`endif
      check("byp_cnt", 32'(busy_cnt), 32'd1);
      @(negedge clk); idle(); #1;
      check("post_rs1", rs1, 32'hDEAD_BEEF);
      check("post_busy", 32'(rs1_busy), 32'd0);
      check("post_cnt", 32'(busy_cnt), 32'd0);

      // async reset mid-write: no edge needed, write and issue lost
      @(negedge clk); idle(); iss_v = 1; iss_addr = 3;
      @(negedge clk); idle();
      rd_w = 1; rd_addr = 2; rd = 32'h1234; iss_v = 1; iss_addr = 2;
      rs1_addr = 6; rs2_addr = 2;
      #1;
      check("pre_rst_cnt", 32'(busy_cnt), 32'd1);
      #1 rst = 1;
      #1;
      check("arst_rs1", rs1, 32'd0);
      check("arst_rs2", rs2, 32'd0);
      check("arst_b1", 32'(rs1_busy), 32'd0);
      check("arst_b2", 32'(rs2_busy), 32'd0);
      check("arst_cnt", 32'(busy_cnt), 32'd0);
      @(negedge clk); idle(); rst = 0;
      rs1_addr = 2; rs2_addr = 3; #1;
      check("lost_wr", rs1, 32'd0);
      check("lost_iss", 32'(rs1_busy), 32'd0);
      check("lost_b3", 32'(rs2_busy), 32'd0);
      check("lost_r3", rs2, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/gpreg_sb.md
Name: gpreg_sb

Overview:
- Parametrised general-purpose register file with a per-register busy scoreboard; successor to the fixed 32x32 gpreg.
- Two combinational read ports, one synchronous write port.
- Register 0 is hardwired to zero.
- The scoreboard tracks registers with an outstanding write, so the issue stage can detect RAW hazards. It sits between decode/issue and writeback in the core.

Parameters:
- XLEN, 32, data width of each register.
- AW, 5, address width; register count NREG = 2**AW.
- CW, AW+1, width of busy_cnt (must hold 0..NREG-1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_w  in  1  writeback enable.
- rd_addr  in  AW  writeback register address.
- rd  in  XLEN  writeback data.
- rs1_addr  in  AW  read port 1 address.
- rs2_addr  in  AW  read port 2 address.
- rs1  out  XLEN  read port 1 data.
- rs2  out  XLEN  read port 2 data.
- iss_v  in  1  issue valid; marks iss_addr busy.
- iss_addr  in  AW  destination register of the issuing instruction.
- flush  in  1  clears all busy bits (pipeline flush).
- rs1_busy  out  1  busy bit of rs1_addr.
- rs2_busy  out  1  busy bit of rs2_addr.
- busy_cnt  out  CW  registered count of busy registers.

Behaviour:
- Clocking and reset:
  - One clock (clk); reset rst is asynchronous and active-high.
  - On rst: all registers = 0, all busy bits = 0, busy_cnt = 0.
  - Because reads are combinational, rs1 = rs2 = 0 and rs1_busy = rs2_busy = 0 while rst is asserted.
  - If rst asserts mid-operation, any write or issue in that cycle is lost.
- Write:
  - At posedge, if rd_w = 1 and rd_addr != 0: regs[rd_addr] <= rd.
  - rd_w = 0 means no state change regardless of rd_addr or rd.
  - Writes to address 0 are discarded.
- Read:
  - Combinational, zero latency: rsN = (rsN_addr == 0) ? 0 : regs[rsN_addr].
  - Both ports may read the same address.
  - Without the bypass feature, a same-cycle write is visible on reads only after the edge.
- Scoreboard, per register i != 0, evaluated at each posedge in priority order:
  1. flush = 1: busy[i] <= 0 for all i. flush overrides iss_v and rd_w; the register write itself still occurs.
  2. iss_v = 1 and iss_addr == i: busy[i] <= 1. Set wins over a same-cycle clear of the same address, because the new producer supersedes the completing one.
  3. rd_w = 1 and rd_addr == i: busy[i] <= 0.
  4. Otherwise busy[i] holds.
- busy[0] is constant 0; issue to address 0 is ignored.
- rsN_busy = busy[rsN_addr], combinational.
- busy_cnt is registered: at each posedge it equals the population count of the next-state busy vector. Its latency matches the busy bits; maximum value is NREG-1.
- Clearing an already-clear busy bit is a no-op. Re-issuing to an already-busy register keeps it busy and leaves the count unchanged.

Optional Feature:
- Macro: GPREG_SB_BYPASS_EN.
- Defined:
  - Write-to-read forwarding: if rd_w = 1, rd_addr != 0 and rd_addr == rsN_addr, then rsN = rd in the same cycle.
  - rsN_busy is forced to 0 in that case, unless iss_v = 1 with iss_addr == rsN_addr in the same cycle.
- Undefined:
  - Reads return the pre-edge register contents.
  - rsN_busy reflects the pre-edge busy bit.

Test Plan:
1. Reset, then rs1_addr = 1, rs2_addr = 18 with rd_w = 0 -> rs1 = 0, rs2 = 0, busy_cnt = 0.
2. rd_w = 1, write rd = 32-i to address i for i = 0..31, then sweep reads -> reg0 = 0; regs[i] = 32-i for i = 1..31 (e.g. regs[1] = 31, regs[18] = 14).
3. rd_w = 0, drive rd = i at address i for all i, then sweep rs1_addr = i, rs2_addr = 32-i (mod 32) -> contents unchanged from scenario 2.
4. iss_v on addresses 3, 5, 0 in consecutive cycles -> rs1_busy for 3 and 5 = 1, busy at 0 = 0, busy_cnt = 2. Then rd_w to 3 -> busy_cnt = 1. Then iss_v = 1 and rd_w = 1 both on address 5 in the same cycle -> addr 5 stays busy, busy_cnt = 1.
5. Busy set on 7 and 9, then flush = 1 with iss_v = 1 to addr 4 in the same cycle -> all busy bits 0, busy_cnt = 0.
6. With GPREG_SB_BYPASS_EN defined: busy on 6, rs1_addr = 6, rd_w = 1, rd_addr = 6, rd = 32'hDEAD_BEEF -> rs1 = DEADBEEF and rs1_busy = 0 before the edge. Without the macro, rs1 shows the old value and rs1_busy = 1 until the edge.
7. Assert rst asynchronously mid-write -> all outputs 0 immediately, with no clock edge.
